// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS DATA_WIDTH-bit read/write registers.
//
// Ports:
//   ACLK, ARESETN                   clock, async active-low reset
//   S_AXI_AW*  / S_AXI_W*           write address / write data channels
//   S_AXI_B*                        write response channel
//   S_AXI_AR*  / S_AXI_R*           read address / read data channels
//
// Build option: define AXIL_REGFILE_DECERR_EN to answer out-of-range
// accesses with DECERR instead of OKAY (no write, RDATA=0 either way).
`timescale 1ns/1ps

module axil_regfile_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned SPAN     = NUM_REGS * STRB_W;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b11;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // Write channel sequencing: which of AW/W is held, commit, response
  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_W,
    W_BOTH,
    W_RESP
  } wstate_t;

  wstate_t                 wstate;
  wstate_t                 wnext_c;
  logic                    commit_c;
  logic                    aw_hs_c;
  logic                    w_hs_c;
  logic                    ar_hs_c;
  logic                    rvalid_nx_c;

  logic                    awready_q;
  logic                    wready_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    aw_in_range;
  logic [IDX_W-1:0]        aw_idx;
  logic                    ar_in_range_c;
  logic [IDX_W-1:0]        ar_idx_c;

  assign aw_hs_c = S_AXI_AWVALID & awready_q;
  assign w_hs_c  = S_AXI_WVALID & wready_q;
  assign ar_hs_c = S_AXI_ARVALID & arready_q;

  assign aw_in_range   = awaddr_q < ADDR_WIDTH'(SPAN);
  assign aw_idx        = awaddr_q[ADDR_LSB +: IDX_W];
  assign ar_in_range_c = S_AXI_ARADDR < ADDR_WIDTH'(SPAN);
  assign ar_idx_c      = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  // Write next-state logic
  always_comb begin
    wnext_c  = wstate;
    commit_c = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) wnext_c = W_BOTH;
        else if (aw_hs_c)      wnext_c = W_AW;
        else if (w_hs_c)       wnext_c = W_W;
      end
      W_AW:   if (w_hs_c)  wnext_c = W_BOTH;
      W_W:    if (aw_hs_c) wnext_c = W_BOTH;
      W_BOTH: begin
        commit_c = 1'b1;
        wnext_c  = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) wnext_c = W_IDLE;
      default: wnext_c = W_IDLE;
    endcase
  end

  // Write state, readies and response; readies follow the next state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wstate    <= wnext_c;
      awready_q <= (wnext_c == W_IDLE) || (wnext_c == W_W);
      wready_q  <= (wnext_c == W_IDLE) || (wnext_c == W_AW);
      bvalid_q  <= (wnext_c == W_RESP);
      if (commit_c) bresp_q <= aw_in_range ? RESP_OKAY : RESP_OOR;
      if (aw_hs_c)  awaddr_q <= S_AXI_AWADDR;
      if (w_hs_c) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register array with byte-strobed commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[IDX_W'(i)] <= '0;
    end else if (commit_c && aw_in_range) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) regs[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Read valid next value; ARREADY mirrors its complement
  always_comb begin
    rvalid_nx_c = rvalid_q;
    if (ar_hs_c)                    rvalid_nx_c = 1'b1;
    else if (rvalid_q && S_AXI_RREADY) rvalid_nx_c = 1'b0;
  end

  // Read capture; same-edge commits are not visible (pre-write value)
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= !rvalid_nx_c;
      rvalid_q  <= rvalid_nx_c;
      if (ar_hs_c) begin
        rdata_q <= ar_in_range_c ? regs[ar_idx_c] : '0;
        rresp_q <= ar_in_range_c ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed self-checking bench for axil_regfile_slave (default parameters).
`timescale 1ns/1ps

module tb_axil_regfile_slave;

`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  localparam logic [1:0] OKAY = 2'b00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  axil_regfile_slave dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write with optional W lead (cycles W precedes AW) and B backpressure
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int bp,
                          input logic [1:0] exp_resp);
    logic aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    wvalid  = 1'b1;
    awvalid = (w_lead == 0);
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 30) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      cyc++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w) begin
        wvalid = 1'b0;
        w_done = 1'b1;
        if (w_lead > 0) check_eq("wready_drop", wready, 0);
      end
      if (w_lead > 0 && w_done && !aw_done && !hs_w) begin
        check_eq("wready_held", wready, 0);
        check_eq("awready_open", awready, 1);
      end
      if (!aw_done && w_done && cyc >= w_lead) awvalid = 1'b1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_eq("wr_timeout", aw_done && w_done, 1);
    check_eq("b_early", bvalid, 0);
    tick();
    check_eq("b_latency", bvalid, 1);
    check_eq("bresp", bresp, exp_resp);
    for (int i = 0; i < bp; i++) begin
      tick();
      check_eq("b_hold_valid", bvalid, 1);
      check_eq("b_hold_resp", bresp, exp_resp);
      check_eq("b_hold_awready", awready, 0);
      check_eq("b_hold_wready", wready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("b_clear", bvalid, 0);
    check_eq("awready_back", awready, 1);
    check_eq("wready_back", wready, 1);
  endtask

  // Read with R backpressure of bp cycles
  task automatic do_read(input logic [31:0] addr, input int bp,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic done, hs;
    int cyc;
    araddr  = addr;
    arvalid = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 30) begin
      hs = arready;
      tick();
      cyc++;
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    check_eq("rd_timeout", done, 1);
    check_eq("rd_latency", rvalid, 1);
    check_eq("rdata", rdata, exp_data);
    check_eq("rresp", rresp, exp_resp);
    for (int i = 0; i < bp; i++) begin
      tick();
      check_eq("r_hold_valid", rvalid, 1);
      check_eq("r_hold_data", rdata, exp_data);
      check_eq("r_hold_resp", rresp, exp_resp);
      check_eq("r_hold_arready", arready, 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("r_clear", rvalid, 0);
    check_eq("arready_back", arready, 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0, model[i], OKAY);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_awready", awready, 1);
    check_eq("rel_wready", wready, 1);
    check_eq("rel_arready", arready, 1);

    // Same-cycle AW+W then read back
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, OKAY);
    model[2] = 32'hDEADBEEF;
    do_read(32'h08, 0, 32'hDEADBEEF, OKAY);

    // W three cycles ahead of AW
    do_write(32'h0C, 32'h11223344, 4'hF, 3, 0, OKAY);
    model[3] = 32'h11223344;
    do_read(32'h0C, 0, 32'h11223344, OKAY);

    // Partial strobe: bytes 0 and 2 replaced
    do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, OKAY);
    do_write(32'h04, 32'h12345678, 4'h5, 0, 0, OKAY);
    model[1] = 32'hAA34CC78;
    do_read(32'h04, 0, 32'hAA34CC78, OKAY);

    // Zero strobe leaves register unchanged
    do_write(32'h08, 32'h01234567, 4'h0, 0, 0, OKAY);
    do_read(32'h08, 0, 32'hDEADBEEF, OKAY);

    // Backpressure on B and R
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 5, OKAY);
    model[4] = 32'hCAFEF00D;
    do_read(32'h10, 5, 32'hCAFEF00D, OKAY);

    // Low address bits ignored; last register
    do_read(32'h0B, 0, 32'hDEADBEEF, OKAY);
    do_write(32'h3C, 32'h5A5AA5A5, 4'hF, 0, 0, OKAY);
    model[15] = 32'h5A5AA5A5;
    do_read(32'h3F, 0, 32'h5A5AA5A5, OKAY);

    // Out of range
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, OOR_RESP);
    read_all();
    do_read(32'h40, 0, 32'h0, OOR_RESP);
    do_read(32'h1000, 0, 32'h0, OOR_RESP);

    // Reset after AW, before W: transaction abandoned
    awaddr  = 32'h14;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_eq("aw_taken", awready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_awready", awready, 0);
    check_eq("midrst_bvalid", bvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_awready", awready, 1);
    check_eq("post_rst_wready", wready, 1);
    for (int i = 0; i < 5; i++) begin
      check_eq("post_rst_no_b", bvalid, 0);
      tick();
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
    read_all();

    // Same-edge commit and read of index 0 returns old value
    awaddr = 32'h00; wdata = 32'h5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("col_hold_b", bvalid, 0);
    araddr = 32'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("col_bvalid", bvalid, 1);
    check_eq("col_rvalid", rvalid, 1);
    check_eq("col_rdata_old", rdata, 32'h0);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check_eq("col_b_clear", bvalid, 0);
    check_eq("col_r_clear", rvalid, 0);
    do_read(32'h00, 0, 32'h5, OKAY);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
